// File: rtl/mips_main_control_if.sv
// Control bundle between the MIPS multi-cycle control FSM and the datapath.
// The master modport is the control unit. The slave modport is the datapath,
// which supplies the opcode and the memory handshake.
interface mips_main_control_if #(
    parameter int OPCODE_WIDTH = 6,
    parameter int CNT_WIDTH    = 32
);
    logic [OPCODE_WIDTH-1:0] Opcode;
    logic                    Mem_Ready;
    logic                    PCWrite;
    logic                    PCWriteCond;
    logic                    IorD;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    MemtoReg;
    logic                    IRWrite;
    logic                    RegWrite;
    logic                    RegDst;
    logic                    ALUSrcA;
    logic [1:0]              ALUSrcB;
    logic [1:0]              ALUOp;
    logic [1:0]              PCSource;
    logic [3:0]              State;
    logic                    Illegal_Op;
    logic [CNT_WIDTH-1:0]    Instr_Count;

    modport master (
        input  Opcode, Mem_Ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
               Illegal_Op, Instr_Count
    );

    modport slave (
        output Opcode, Mem_Ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
               Illegal_Op, Instr_Count
    );
endinterface

// File: rtl/mips_main_control.sv
// Moore-style multi-cycle MIPS main control FSM.
// It sequences fetch, decode, execute, memory and write-back, stalls on
// Mem_Ready, and counts retired instructions. Control outputs decode
// combinationally from the state register and are held at zero while RST is
// asserted.
module mips_main_control #(
    parameter int OPCODE_WIDTH = 6,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    mips_main_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_count;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_to_reg;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_illegal;
    logic       w_opcode_ok;

    // Flags whether the current opcode is one of the six supported instructions.
    always_comb begin
        w_opcode_ok = 1'b0;
        if (bus.Opcode == OP_RTYPE || bus.Opcode == OP_LW   ||
            bus.Opcode == OP_SW    || bus.Opcode == OP_BEQ  ||
            bus.Opcode == OP_J     || bus.Opcode == OP_ADDI) begin
            w_opcode_ok = 1'b1;
        end
    end

    // Advances the state register and counts instructions on their final cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.Mem_Ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) begin
                        r_state <= S_MEM_ADDR;
                    end else if (bus.Opcode == OP_RTYPE) begin
                        r_state <= S_R_EXEC;
                    end else if (bus.Opcode == OP_BEQ) begin
                        r_state <= S_BRANCH;
                    end else if (bus.Opcode == OP_J) begin
                        r_state <= S_JUMP;
                    end else if (bus.Opcode == OP_ADDI) begin
                        r_state <= S_ADDI_EXEC;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM_ADDR: begin
                    if (bus.Opcode == OP_LW) begin
                        r_state <= S_MEM_READ;
                    end else if (bus.Opcode == OP_SW) begin
                        r_state <= S_MEM_WRITE;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM_READ: begin
                    if (bus.Mem_Ready) begin
                        r_state <= S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + 1'b1;
                end
                S_MEM_WRITE: begin
                    if (bus.Mem_Ready) begin
                        r_state <= S_FETCH;
                        r_count <= r_count + 1'b1;
                    end
                end
                S_R_EXEC:    r_state <= S_R_WB;
                S_R_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + 1'b1;
                end
                S_BRANCH: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + 1'b1;
                end
                S_JUMP: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + 1'b1;
                end
                S_ADDI_EXEC: r_state <= S_ADDI_WB;
                S_ADDI_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + 1'b1;
                end
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls. The reset gate is combinational, so
    // an asynchronous reset clears the strobes immediately, not at the next edge.
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_illegal       = 1'b0;
        if (!RST) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_read  = 1'b1;
                    w_alu_src_b = 2'b01;
                    w_ir_write  = bus.Mem_Ready;
                    w_pc_write  = bus.Mem_Ready;
                end
                S_DECODE: begin
                    w_alu_src_b = 2'b11;
                    w_illegal   = ~w_opcode_ok;
                end
                S_MEM_ADDR: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    w_mem_read = 1'b1;
                    w_iord     = 1'b1;
                end
                S_MEM_WB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    w_mem_write = 1'b1;
                    w_iord      = 1'b1;
                end
                S_R_EXEC: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = 2'b10;
                end
                S_R_WB: begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    w_alu_src_a     = 1'b1;
                    w_alu_op        = 2'b01;
                    w_pc_write_cond = 1'b1;
                    w_pc_source     = 2'b01;
                end
                S_JUMP: begin
                    w_pc_write  = 1'b1;
                    w_pc_source = 2'b10;
                end
                S_ADDI_EXEC: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    w_reg_write = 1'b1;
                end
                default: begin
                    w_pc_write = 1'b0;
                end
            endcase
        end
    end

    assign bus.PCWrite     = w_pc_write;
    assign bus.PCWriteCond = w_pc_write_cond;
    assign bus.IorD        = w_iord;
    assign bus.MemRead     = w_mem_read;
    assign bus.MemWrite    = w_mem_write;
    assign bus.MemtoReg    = w_mem_to_reg;
    assign bus.IRWrite     = w_ir_write;
    assign bus.RegWrite    = w_reg_write;
    assign bus.RegDst      = w_reg_dst;
    assign bus.ALUSrcA     = w_alu_src_a;
    assign bus.ALUSrcB     = w_alu_src_b;
    assign bus.ALUOp       = w_alu_op;
    assign bus.PCSource    = w_pc_source;
    assign bus.Illegal_Op  = w_illegal;
    assign bus.State       = r_state;
    assign bus.Instr_Count = r_count;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control with a 4-bit instruction counter.
// The stimulus process drives one cycle at a time and queues the expected outputs
// for that cycle. The monitor process checks them on the falling edge.
module tb_mips_main_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic CLK;
    logic RST;

    mips_main_control_if #(.OPCODE_WIDTH(6), .CNT_WIDTH(4)) bus ();

    mips_main_control #(.OPCODE_WIDTH(6), .CNT_WIDTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control bits: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
    // IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB[2], ALUOp[2], PCSource[2], Illegal_Op}.
    function automatic logic [16:0] ctl_exp(input logic rst, input logic [3:0] st,
                                            input logic mr, input logic ill);
        logic [16:0] v;
        v = '0;
        if (!rst) begin
            case (st)
                4'd0:  v = {mr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mr, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
                4'd1:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, ill};
                4'd2:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
                4'd3:  v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
                4'd4:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
                4'd5:  v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
                4'd6:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
                4'd7:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
                4'd8:  v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
                4'd9:  v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
                4'd10: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
                4'd11: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Drives one cycle of inputs, queues the expected outputs, and advances to
    // 1 time unit after the next rising edge.
    task automatic step(input logic rst, input logic mr, input logic [5:0] op,
                        input logic [3:0] st, input logic [3:0] cnt, input logic ill);
        exp_t e;
        RST           = rst;
        bus.Mem_Ready = mr;
        bus.Opcode    = op;
        e.st  = st;
        e.ctl = ctl_exp(rst, st, mr, ill);
        e.cnt = cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares each queued expectation against the DUT on the falling edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [16:0] act_ctl;
            e = sb.pop_front();
            act_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                       bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Illegal_Op};
            checks = checks + 3;
            if (bus.State !== e.st) begin
                errors = errors + 1;
                $display("FAIL state at %0t: got %0d expected %0d", $time, bus.State, e.st);
            end
            if (act_ctl !== e.ctl) begin
                errors = errors + 1;
                $display("FAIL ctl at %0t (state %0d): got %b expected %b", $time, e.st, act_ctl, e.ctl);
            end
            if (bus.Instr_Count !== e.cnt) begin
                errors = errors + 1;
                $display("FAIL count at %0t: got %0d expected %0d", $time, bus.Instr_Count, e.cnt);
            end
        end
    end

    initial begin
        RST           = 1'b1;
        bus.Mem_Ready = 1'b1;
        bus.Opcode    = OP_R;
        @(posedge CLK);
        #1;

        // Reset state.
        step(1'b1, 1'b1, OP_R, 4'd0, 4'd0, 1'b0);

        // R-type: 0,1,6,7 and then back to 0 with the count at 1.
        step(1'b0, 1'b1, OP_R, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b1, OP_R, 4'd1, 4'd0, 1'b0);
        step(1'b0, 1'b1, OP_R, 4'd6, 4'd0, 1'b0);
        step(1'b0, 1'b1, OP_R, 4'd7, 4'd0, 1'b0);

        // lw: 3 stall cycles in MEM_READ.
        step(1'b0, 1'b1, OP_LW, 4'd0, 4'd1, 1'b0);
        step(1'b0, 1'b1, OP_LW, 4'd1, 4'd1, 1'b0);
        step(1'b0, 1'b1, OP_LW, 4'd2, 4'd1, 1'b0);
        step(1'b0, 1'b0, OP_LW, 4'd3, 4'd1, 1'b0);
        step(1'b0, 1'b0, OP_LW, 4'd3, 4'd1, 1'b0);
        step(1'b0, 1'b0, OP_LW, 4'd3, 4'd1, 1'b0);
        step(1'b0, 1'b1, OP_LW, 4'd3, 4'd1, 1'b0);
        step(1'b0, 1'b1, OP_LW, 4'd4, 4'd1, 1'b0);

        // sw: one FETCH stall first, with Mem_Ready = 1 in MEM_WRITE.
        step(1'b0, 1'b0, OP_SW, 4'd0, 4'd2, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd0, 4'd2, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd1, 4'd2, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd2, 4'd2, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd5, 4'd2, 1'b0);

        // sw with one MEM_WRITE stall; the count must not move on the stall cycle.
        step(1'b0, 1'b1, OP_SW, 4'd0, 4'd3, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd1, 4'd3, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd2, 4'd3, 1'b0);
        step(1'b0, 1'b0, OP_SW, 4'd5, 4'd3, 1'b0);
        step(1'b0, 1'b1, OP_SW, 4'd5, 4'd3, 1'b0);

        // beq
        step(1'b0, 1'b1, OP_BEQ, 4'd0, 4'd4, 1'b0);
        step(1'b0, 1'b1, OP_BEQ, 4'd1, 4'd4, 1'b0);
        step(1'b0, 1'b1, OP_BEQ, 4'd8, 4'd4, 1'b0);

        // addi
        step(1'b0, 1'b1, OP_ADDI, 4'd0, 4'd5, 1'b0);
        step(1'b0, 1'b1, OP_ADDI, 4'd1, 4'd5, 1'b0);
        step(1'b0, 1'b1, OP_ADDI, 4'd10, 4'd5, 1'b0);
        step(1'b0, 1'b1, OP_ADDI, 4'd11, 4'd5, 1'b0);

        // R-type aborted by reset while in R_WB: everything clears before any edge.
        step(1'b0, 1'b1, OP_R, 4'd0, 4'd6, 1'b0);
        step(1'b0, 1'b1, OP_R, 4'd1, 4'd6, 1'b0);
        step(1'b0, 1'b1, OP_R, 4'd6, 4'd6, 1'b0);
        step(1'b1, 1'b1, OP_R, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b1, OP_R, 4'd0, 4'd0, 1'b0);

        // Illegal opcode: one-cycle pulse in DECODE, no count increment.
        step(1'b0, 1'b1, OP_BAD, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b1, OP_BAD, 4'd1, 4'd0, 1'b1);

        // Sixteen jumps: the count climbs to 15, then wraps to 0.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] c;
            c = 4'(i);
            step(1'b0, 1'b1, OP_J, 4'd0, c, 1'b0);
            step(1'b0, 1'b1, OP_J, 4'd1, c, 1'b0);
            step(1'b0, 1'b1, OP_J, 4'd9, c, 1'b0);
        end
        step(1'b0, 1'b1, OP_J, 4'd0, 4'd0, 1'b0);

        // Let the monitor drain the queue, with a bound on the wait.
        for (int k = 0; k < 5; k++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
            #1;
        end
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Moore-style multi-cycle control FSM for the MIPS datapath. Decodes the instruction opcode and sequences each instruction through fetch, decode, execute, memory and write-back cycles. Drives the register-file write strobe and destination/data selects, plus all PC, memory, IR and ALU control lines. Stalls on a memory-ready handshake and keeps a retired-instruction counter.

## Interface
- OPCODE_WIDTH, 6, opcode field width
- CNT_WIDTH, 32, retired-instruction counter width
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- Opcode  input  OPCODE_WIDTH  IR[31:26], valid from DECODE onward
- Mem_Ready  input  1  memory has completed the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite  output  1 each  datapath strobes/selects
- RegWrite  output  1  register-file write enable
- RegDst  output  1  write register select: 1 = rd, 0 = rt
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- State  output  4  current state encoding, for debug
- Illegal_Op  output  1  one-cycle pulse on an unsupported opcode in DECODE
- Instr_Count  output  CNT_WIDTH  count of retired instructions

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 R_EXEC, 7 R_WB, 8 BRANCH, 9 JUMP, 10 ADDI_EXEC, 11 ADDI_WB.
  - 12-15 are unused and recover to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite = Mem_Ready.
  - Stays in FETCH until Mem_Ready = 1, then goes to DECODE.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
  - Next state: lw/sw -> MEM_ADDR; R -> R_EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EXEC.
  - Any other opcode -> FETCH with Illegal_Op = 1; the instruction is not counted.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead = 1, IorD = 1. Holds until Mem_Ready, then -> MEM_WB.
- MEM_WB: RegWrite = 1, RegDst = 0, MemtoReg = 1. Then -> FETCH; the instruction retires.
- MEM_WRITE: MemWrite = 1, IorD = 1. Holds until Mem_Ready, then -> FETCH; retires on the Mem_Ready cycle.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Then -> R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Then -> FETCH; retires.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Then -> FETCH; retires.
- JUMP: PCWrite = 1, PCSource = 10. Then -> FETCH; retires.
- ADDI_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Then -> ADDI_WB.
- ADDI_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Then -> FETCH; retires.
- All outputs not listed for a state are 0.
- Instr_Count:
  - Increments by 1 on the last cycle of each retiring state.
  - Wraps modulo 2^CNT_WIDTH.
  - Never increments on Illegal_Op or on stall cycles.

## Timing
- The state register and Instr_Count update on the rising edge of CLK.
- All control outputs are combinational from State. Mem_Ready additionally gates IRWrite/PCWrite in FETCH and the exit from the memory-wait states.
- While RST = 1:
  - State = 0 and Instr_Count = 0.
  - Every control output, including Illegal_Op, is forced to 0.
  - This prevents spurious RegWrite or PCWrite during reset.
- Reset asserted mid-instruction aborts it immediately; nothing retires. After release, FETCH begins on the first edge.
- Minimum cycles per instruction with Mem_Ready held at 1:
  - lw 5; sw, R-type and addi 4; beq and j 3.
  - Each cycle with Mem_Ready = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- RegWrite is high for exactly one cycle per lw, R-type or addi instruction. The register-file write occurs on the edge that ends MEM_WB, R_WB or ADDI_WB.
- Opcode is sampled only in DECODE and MEM_ADDR, and must be stable from DECODE until the instruction completes.

## Test plan
- Reset, Mem_Ready = 1, Opcode = 000000 → State sequence 0,1,6,7,0. RegWrite = 1 and RegDst = 1 only in state 7. Instr_Count = 1 after 4 cycles.
- lw (100011) with Mem_Ready low for 3 cycles in MEM_READ → sequence 0,1,2,3,3,3,3,4,0. RegWrite = 1 and MemtoReg = 1 only in state 4. Count +1.
- sw (101011), Mem_Ready = 1 → sequence 0,1,2,5,0. MemWrite = 1 for one cycle. RegWrite is never asserted.
- Opcode 111111 → Illegal_Op pulses for one cycle in DECODE, the FSM returns to FETCH, and Instr_Count is unchanged.
- Assert RST while in R_WB → all outputs 0 immediately (asynchronous), State = 0, Instr_Count = 0, no RegWrite pulse.
- Preload Instr_Count to all 1s (run 2^CNT_WIDTH−1 j instructions, CNT_WIDTH reduced to 4 in the bench), then one more j → Instr_Count wraps to 0.
